// File: rtl/seg7_scan_if.sv
// Display bus between a seg7_scan driver and its user.
// Carries the value/enable inputs and the anode/cathode pins.
interface seg7_scan_if;
  logic [15:0] value;
  logic        en;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output value, en, dp_mask,
    input  an, seg, dp
  );

  modport slave (
    input  value, en, dp_mask,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_scan.sv
// Four-digit multiplexed hex display driver with per-frame capture.
// Define SEG7_LZ_BLANK_EN to enable leading-zero blanking.
module seg7_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  seg7_scan_if.slave  bus
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    nib;
  logic          supp;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    unique case (n)
      4'h0: p = 7'b1000000;
      4'h1: p = 7'b1111001;
      4'h2: p = 7'b0100100;
      4'h3: p = 7'b0110000;
      4'h4: p = 7'b0011001;
      4'h5: p = 7'b0010010;
      4'h6: p = 7'b0000010;
      4'h7: p = 7'b1111000;
      4'h8: p = 7'b0000000;
      4'h9: p = 7'b0010000;
      4'hA: p = 7'b0001000;
      4'hB: p = 7'b0000011;
      4'hC: p = 7'b1000110;
      4'hD: p = 7'b0100001;
      4'hE: p = 7'b0000110;
      default: p = 7'b0001110;
    endcase
    return p;
  endfunction

  assign nib = shadow_q[{idx_q, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
  // A digit goes dark when it and every digit left of it is zero.
  always_comb begin
    supp = 1'b0;
    unique case (idx_q)
      2'd3: supp = (shadow_q[15:12] == 4'h0);
      2'd2: supp = (shadow_q[15:8] == 8'h00);
      2'd1: supp = (shadow_q[15:4] == 12'h000);
      default: supp = 1'b0;
    endcase
  end
`else
  assign supp = 1'b0;
`endif

  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    an_d     = 4'b1111;
    seg_d    = 7'b1111111;
    dp_d     = 1'b1;
    if (bus.en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (idx_q == 2'd0 && cnt_q == '0)
        shadow_d = bus.value;
      if (cnt_q >= BLANK && !supp) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = hex7(nib);
        dp_d  = ~bus.dp_mask[idx_q];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      an_q     <= 4'b1111;
      seg_q    <= 7'b1111111;
      dp_q     <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: vector table, hand sequences and a
// random run checked against a slot-position reference model.
module tb_seg7_scan;
  localparam int R = 8;
  localparam int B = 2;
  localparam int F = 4 * R;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  seg7_scan_if bus_if ();

  seg7_scan #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int edges = 0;
  int p = 0;
  logic [15:0] msh = 16'h0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  mask;
    int          slot;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;
  vec_t vt [16];

  function automatic logic [6:0] pat(input int n);
    logic [6:0] t [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  task automatic check(input string nm, input logic [3:0] an,
                       input logic [6:0] seg, input logic dp);
    n_chk++;
    if (bus_if.an !== an || bus_if.seg !== seg ||
        bus_if.dp !== dp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
               nm, edges, bus_if.an, bus_if.seg, bus_if.dp,
               an, seg, dp);
    end
  endtask

  // Expected outputs from the running slot position p.
  task automatic model_exp(output logic [3:0] an,
                           output logic [6:0] seg,
                           output logic dp);
    int slot, off;
    bit sup;
    an = 4'hF; seg = 7'h7F; dp = 1'b1;
    slot = p / R;
    off = p % R;
    sup = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
    sup = (slot > 0) && ((int'(msh) >> (4 * slot)) == 0);
`endif
    if (bus_if.en && off >= B && !sup) begin
      an = 4'hF & ~(4'h1 << slot);
      seg = pat(int'((msh >> (4 * slot)) & 16'hF));
      dp = ~bus_if.dp_mask[slot];
    end
  endtask

  task automatic tick();
    logic [3:0] ea;
    logic [6:0] es;
    logic ed;
    model_exp(ea, es, ed);
    if (bus_if.en) begin
      if (p == 0) msh = bus_if.value;
      p = (p + 1) % F;
    end
    @(posedge CLK);
    @(negedge CLK);
    edges++;
    check("model", ea, es, ed);
  endtask

  task automatic run_to(input int n);
    while (edges < n) tick();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    check("reset", 4'hF, 7'h7F, 1'b1);
    @(negedge CLK);
    RST = 1'b0;
    p = 0; msh = 16'h0; edges = 0;
  endtask

  initial begin
    bus_if.value = 16'h0;
    bus_if.en = 1'b0;
    bus_if.dp_mask = 4'h0;
    vt[0]  = '{16'h8880, 4'h0, 0, 4'b1110, 7'b1000000, 1'b1};
    vt[1]  = '{16'h1000, 4'h0, 3, 4'b0111, 7'b1111001, 1'b1};
    vt[2]  = '{16'h8828, 4'h2, 1, 4'b1101, 7'b0100100, 1'b0};
    vt[3]  = '{16'h8388, 4'h4, 2, 4'b1011, 7'b0110000, 1'b0};
    vt[4]  = '{16'h1234, 4'h4, 0, 4'b1110, 7'b0011001, 1'b1};
    vt[5]  = '{16'h5000, 4'h0, 3, 4'b0111, 7'b0010010, 1'b1};
    vt[6]  = '{16'hF060, 4'h0, 1, 4'b1101, 7'b0000010, 1'b1};
    vt[7]  = '{16'h1700, 4'h0, 2, 4'b1011, 7'b1111000, 1'b1};
    vt[8]  = '{16'h0008, 4'h0, 0, 4'b1110, 7'b0000000, 1'b1};
    vt[9]  = '{16'h9999, 4'h8, 3, 4'b0111, 7'b0010000, 1'b0};
    vt[10] = '{16'hABCD, 4'h0, 3, 4'b0111, 7'b0001000, 1'b1};
    vt[11] = '{16'hABCD, 4'h0, 2, 4'b1011, 7'b0000011, 1'b1};
    vt[12] = '{16'hABCD, 4'h0, 1, 4'b1101, 7'b1000110, 1'b1};
    vt[13] = '{16'hABCD, 4'h1, 0, 4'b1110, 7'b0100001, 1'b0};
    vt[14] = '{16'hE000, 4'h0, 3, 4'b0111, 7'b0000110, 1'b1};
    vt[15] = '{16'h100F, 4'hE, 0, 4'b1110, 7'b0001110, 1'b1};

    @(negedge CLK);
    do_reset();

    // Reset release, scan order and tear-free capture.
    bus_if.value = 16'h1234;
    bus_if.en = 1'b1;
    run_to(2);  check("blank0", 4'hF, 7'h7F, 1'b1);
    run_to(3);  check("d0_first", 4'b1110, 7'b0011001, 1'b1);
    run_to(8);  check("d0_last", 4'b1110, 7'b0011001, 1'b1);
    run_to(9);  check("slot1_dark", 4'hF, 7'h7F, 1'b1);
    run_to(10);
    bus_if.value = 16'hABCD;
    run_to(11); check("d1", 4'b1101, 7'b0110000, 1'b1);
    run_to(19); check("old_d2", 4'b1011, 7'b0100100, 1'b1);
    run_to(27); check("old_d3", 4'b0111, 7'b1111001, 1'b1);
    run_to(35); check("new_d0", 4'b1110, 7'b0100001, 1'b1);
    run_to(43); check("new_d1", 4'b1101, 7'b1000110, 1'b1);
    run_to(51); check("new_d2", 4'b1011, 7'b0000011, 1'b1);
    run_to(59); check("new_d3", 4'b0111, 7'b0001000, 1'b1);

    // Asynchronous reset while a digit is lit.
    #2 RST = 1'b1;
    #1 check("async_rst", 4'hF, 7'h7F, 1'b1);
    @(negedge CLK);
    RST = 1'b0;
    p = 0; msh = 16'h0; edges = 0;

    // Enable gap inside digit 2, with its decimal point.
    bus_if.value = 16'h1234;
    bus_if.dp_mask = 4'b0100;
    run_to(3);  check("dp_d0", 4'b1110, 7'b0011001, 1'b1);
    run_to(20); check("dp_d2", 4'b1011, 7'b0100100, 1'b0);
    bus_if.en = 1'b0;
    run_to(21); check("en_off", 4'hF, 7'h7F, 1'b1);
    run_to(25);
    bus_if.en = 1'b1;
    run_to(26); check("en_back", 4'b1011, 7'b0100100, 1'b0);
    run_to(29); check("d2_tail", 4'b1011, 7'b0100100, 1'b0);
    run_to(30); check("d3_blank", 4'hF, 7'h7F, 1'b1);
    bus_if.dp_mask = 4'h0;

    // Leading zeros.
    do_reset();
    bus_if.value = 16'h0050;
    bus_if.en = 1'b1;
    run_to(3);  check("lz_d0", 4'b1110, 7'b1000000, 1'b1);
    run_to(11); check("lz_d1", 4'b1101, 7'b0010010, 1'b1);
`ifdef SEG7_LZ_BLANK_EN
    run_to(19); check("lz_d2", 4'hF, 7'h7F, 1'b1);
    run_to(27); check("lz_d3", 4'hF, 7'h7F, 1'b1);
`else
    run_to(19); check("lz_d2", 4'b1011, 7'b1000000, 1'b1);
    run_to(27); check("lz_d3", 4'b0111, 7'b1000000, 1'b1);
`endif
    do_reset();
    bus_if.value = 16'h0000;
    run_to(3);  check("z_d0", 4'b1110, 7'b1000000, 1'b1);
`ifdef SEG7_LZ_BLANK_EN
    run_to(11); check("z_d1", 4'hF, 7'h7F, 1'b1);
`else
    run_to(11); check("z_d1", 4'b1101, 7'b1000000, 1'b1);
`endif

    // Pattern table, one lit sample per record.
    for (int i = 0; i < 16; i++) begin
      do_reset();
      bus_if.value = vt[i].value;
      bus_if.dp_mask = vt[i].mask;
      bus_if.en = 1'b1;
      run_to(vt[i].slot * R + B + 1);
      check($sformatf("vec%0d", i), vt[i].an, vt[i].seg, vt[i].dp);
    end

    // Random run against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) bus_if.value = 16'($urandom);
      if ($urandom_range(0, 19) == 0) bus_if.dp_mask = 4'($urandom);
      bus_if.en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) bus_if.value[15:8] = 8'h00;
      if ($urandom_range(0, 599) == 0) do_reset();
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
